// File: rtl/mp4_mem_pkg.sv
// rtl/mp4_mem_pkg.sv - shared types and sizes for the mp4 line/burst memory path
package mp4_mem_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } line_burst_state_t;

endpackage

// File: rtl/line_burst_adaptor.sv
// rtl/line_burst_adaptor.sv - 256-bit line port to 4-beat 64-bit memory burst adaptor
//
// Purpose: accepts one line read or write from the cache hierarchy at a time and
// runs it as a burst of BEATS beats on the physical memory port. All memory-side
// outputs and the line response are registered.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   line_addr_i              line request byte address
//   line_read_i/line_write_i line requests, held until line_resp_o
//   line_wdata_i             line to write
//   line_rdata_o             assembled read line (held until next read's first beat)
//   line_resp_o              one-cycle completion pulse
//   mem_address_o            line-aligned burst address
//   mem_read_o/mem_write_o   burst requests
//   mem_wdata_o              current write beat
//   mem_rdata_i/mem_resp_i   read beat and beat accept/valid strobe
module line_burst_adaptor #(
    parameter int LINE_WIDTH  = mp4_mem_pkg::LINE_WIDTH,
    parameter int BURST_WIDTH = mp4_mem_pkg::BURST_WIDTH,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  line_addr_i,
    input  logic                   line_read_i,
    input  logic                   line_write_i,
    input  logic [LINE_WIDTH-1:0]  line_wdata_i,
    output logic [LINE_WIDTH-1:0]  line_rdata_o,
    output logic                   line_resp_o,
    output logic [ADDR_WIDTH-1:0]  mem_address_o,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic [BURST_WIDTH-1:0] mem_wdata_o,
    input  logic [BURST_WIDTH-1:0] mem_rdata_i,
    input  logic                   mem_resp_i
);

    import mp4_mem_pkg::*;

    localparam int BEAT_COUNT = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W      = $clog2(BEAT_COUNT);

    line_burst_state_t      r_state;
    logic [CNT_W-1:0]       r_beat;
    logic [LINE_WIDTH-1:0]  r_wline;

    logic [CNT_W-1:0]       w_beat_next;
    logic                   w_last_beat;
    logic [BURST_WIDTH-1:0] w_cur_word;
    logic [BURST_WIDTH-1:0] w_next_word;

    // Counter is exactly wide enough for BEATS, so +1 wraps to 0 after the last beat.
    assign w_beat_next = r_beat + 1'b1;
    assign w_last_beat = (r_beat == CNT_W'(BEAT_COUNT - 1));
    assign w_cur_word  = r_wline[BURST_WIDTH*r_beat +: BURST_WIDTH];
    assign w_next_word = r_wline[BURST_WIDTH*w_beat_next +: BURST_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_beat        <= '0;
            r_wline       <= '0;
            line_rdata_o  <= '0;
            line_resp_o   <= 1'b0;
            mem_address_o <= '0;
            mem_read_o    <= 1'b0;
            mem_write_o   <= 1'b0;
            mem_wdata_o   <= '0;
        end else begin
            line_resp_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (line_write_i || line_read_i) begin
                        mem_address_o <= {line_addr_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        r_wline       <= line_wdata_i;
                        r_beat        <= '0;
                        // Write wins when both requests are raised together.
                        r_state       <= line_write_i ? WRITE : READ;
                    end
                end
                READ: begin
                    // First cycle in READ only raises the request; beats count once it is visible.
                    if (!mem_read_o) begin
                        mem_read_o <= 1'b1;
                    end else if (mem_resp_i) begin
                        line_rdata_o[BURST_WIDTH*r_beat +: BURST_WIDTH] <= mem_rdata_i;
                        r_beat <= w_beat_next;
                        if (w_last_beat) begin
                            mem_read_o <= 1'b0;
                            r_state    <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (!mem_write_o) begin
                        mem_write_o <= 1'b1;
                        mem_wdata_o <= w_cur_word;
                    end else if (mem_resp_i) begin
                        r_beat <= w_beat_next;
                        if (w_last_beat) begin
                            mem_write_o <= 1'b0;
                            r_state     <= DONE;
                        end else begin
                            mem_wdata_o <= w_next_word;
                        end
                    end
                end
                DONE: begin
                    line_resp_o <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(r_state == DONE && mem_resp_i))
                else $error("line_burst_adaptor: mem_resp_i received while in DONE");
            assert (!(mem_read_o && mem_write_o))
                else $error("line_burst_adaptor: mem_read_o and mem_write_o both high");
        end
    end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// tb/tb_line_burst_adaptor.sv - self-checking bench for line_burst_adaptor
module tb_line_burst_adaptor;

    logic         clk;
    logic         rst;
    logic [31:0]  line_addr_i;
    logic         line_read_i;
    logic         line_write_i;
    logic [255:0] line_wdata_i;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic [31:0]  mem_address_o;
    logic         mem_read_o;
    logic         mem_write_o;
    logic [63:0]  mem_wdata_o;
    logic [63:0]  mem_rdata_i;
    logic         mem_resp_i;

    int           tests;
    int           fails;
    logic [255:0] exp_rdata;

    line_burst_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .line_addr_i   (line_addr_i),
        .line_read_i   (line_read_i),
        .line_write_i  (line_write_i),
        .line_wdata_i  (line_wdata_i),
        .line_rdata_o  (line_rdata_o),
        .line_resp_o   (line_resp_o),
        .mem_address_o (mem_address_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_resp_i    (mem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [31:0] aligned(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    task automatic idle(input int n, input bit spurious);
        for (int i = 0; i < n; i++) begin
            line_read_i  = 1'b0;
            line_write_i = 1'b0;
            mem_resp_i   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata_i  = {$urandom, $urandom};
            tick();
            chk("idle_mem_read", mem_read_o, 1'b0);
            chk("idle_mem_write", mem_write_o, 1'b0);
            chk("idle_line_resp", line_resp_o, 1'b0);
            chk("idle_rdata_hold", line_rdata_o, exp_rdata);
        end
        mem_resp_i = 1'b0;
    endtask

    // Full line read; gap < 0 picks a random 0..3 idle cycles before each beat.
    task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int gap);
        int g;
        line_addr_i  = addr;
        line_read_i  = 1'b1;
        line_write_i = 1'b0;
        mem_resp_i   = 1'b0;
        tick();
        chk("rd_req_not_yet", mem_read_o, 1'b0);
        chk("rd_no_resp_accept", line_resp_o, 1'b0);
        tick();
        chk("rd_req_visible", mem_read_o, 1'b1);
        chk("rd_no_write", mem_write_o, 1'b0);
        chk("rd_addr", mem_address_o, aligned(addr));
        for (int k = 0; k < 4; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int j = 0; j < g; j++) begin
                mem_resp_i  = 1'b0;
                mem_rdata_i = {$urandom, $urandom};
                tick();
                chk("rd_gap_req", mem_read_o, 1'b1);
                chk("rd_gap_no_resp", line_resp_o, 1'b0);
            end
            mem_resp_i  = 1'b1;
            mem_rdata_i = line[64*k +: 64];
            tick();
            mem_resp_i  = 1'b0;
            mem_rdata_i = {$urandom, $urandom};
            chk("rd_beat_req", mem_read_o, (k < 3) ? 1'b1 : 1'b0);
            chk("rd_addr_stable", mem_address_o, aligned(addr));
            chk("rd_beat_no_resp", line_resp_o, 1'b0);
        end
        tick();
        exp_rdata = line;
        chk("rd_line_resp", line_resp_o, 1'b1);
        chk("rd_line_data", line_rdata_o, exp_rdata);
        chk("rd_done_req", mem_read_o, 1'b0);
        line_read_i = 1'b0;
    endtask

    // Full line write; both=1 also raises line_read_i to exercise write priority.
    task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int gap, input bit both);
        int g;
        line_addr_i  = addr;
        line_wdata_i = line;
        line_write_i = 1'b1;
        line_read_i  = both;
        mem_resp_i   = 1'b0;
        tick();
        chk("wr_req_not_yet", mem_write_o, 1'b0);
        chk("wr_no_resp_accept", line_resp_o, 1'b0);
        tick();
        chk("wr_req_visible", mem_write_o, 1'b1);
        chk("wr_no_read", mem_read_o, 1'b0);
        chk("wr_addr", mem_address_o, aligned(addr));
        chk("wr_beat0", mem_wdata_o, line[63:0]);
        for (int k = 0; k < 4; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int j = 0; j < g; j++) begin
                mem_resp_i = 1'b0;
                tick();
                chk("wr_gap_req", mem_write_o, 1'b1);
                chk("wr_gap_no_read", mem_read_o, 1'b0);
                chk("wr_gap_data_hold", mem_wdata_o, line[64*k +: 64]);
                chk("wr_rdata_hold", line_rdata_o, exp_rdata);
            end
            mem_resp_i = 1'b1;
            tick();
            mem_resp_i = 1'b0;
            if (k < 3) begin
                chk("wr_next_beat", mem_wdata_o, line[64*(k+1) +: 64]);
                chk("wr_beat_req", mem_write_o, 1'b1);
            end else begin
                chk("wr_last_drop", mem_write_o, 1'b0);
            end
            chk("wr_addr_stable", mem_address_o, aligned(addr));
            chk("wr_beat_no_resp", line_resp_o, 1'b0);
        end
        tick();
        chk("wr_line_resp", line_resp_o, 1'b1);
        chk("wr_rdata_kept", line_rdata_o, exp_rdata);
        chk("wr_done_req", mem_write_o, 1'b0);
        line_write_i = 1'b0;
        line_read_i  = 1'b0;
    endtask

    initial begin
        logic [255:0] l;
        tests        = 0;
        fails        = 0;
        exp_rdata    = '0;
        rst          = 1'b0;
        line_addr_i  = '0;
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        line_wdata_i = '0;
        mem_rdata_i  = '0;
        mem_resp_i   = 1'b0;

        tick();
        tick();
        chk("rst_mem_read", mem_read_o, 1'b0);
        chk("rst_mem_write", mem_write_o, 1'b0);
        chk("rst_addr", mem_address_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 64'h0);
        chk("rst_rdata", line_rdata_o, 256'h0);
        chk("rst_line_resp", line_resp_o, 1'b0);
        rst = 1'b1;
        idle(2, 1'b0);

        // Directed read, back-to-back beats
        l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        do_read(32'h0000_1234, l, 0);
        chk("t1_addr_1220", mem_address_o, 32'h0000_1220);
        idle(2, 1'b0);

        // Directed write with two-cycle gaps
        l = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        do_write(32'h8000_0040, l, 2, 1'b0);
        idle(1, 1'b0);

        // Read and write together: write wins
        do_write(32'h0000_0040, rand_line(), 0, 1'b1);
        idle(1, 1'b0);

        // Reset in the middle of a read
        line_addr_i = 32'h0000_2000;
        line_read_i = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            mem_resp_i  = 1'b1;
            mem_rdata_i = {$urandom, $urandom};
            tick();
        end
        mem_resp_i  = 1'b0;
        rst         = 1'b0;
        line_read_i = 1'b0;
        tick();
        exp_rdata = '0;
        chk("mid_rst_read", mem_read_o, 1'b0);
        chk("mid_rst_rdata", line_rdata_o, 256'h0);
        chk("mid_rst_resp", line_resp_o, 1'b0);
        rst = 1'b1;
        idle(3, 1'b0);
        do_read(32'h0000_0100, rand_line(), 0);

        // Back-to-back read then write, no idle in between
        do_read(32'h0000_0300, rand_line(), -1);
        do_write(32'h0000_0400, rand_line(), -1, 1'b0);

        // Spurious strobes in IDLE must not disturb the next transaction
        idle(6, 1'b1);
        do_read(32'h0000_0500, rand_line(), 0);

        // Randomized transactions
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0:       do_read($urandom, rand_line(), -1);
                1:       do_write($urandom, rand_line(), -1, 1'b0);
                default: do_write($urandom, rand_line(), -1, 1'b1);
            endcase
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)), 1'b1);
        end
        idle(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
